// File: rtl/md_ctl_pkg.sv
// Purpose: shared definitions for the MD timestep control path (sequencer states, default widths).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package md_ctl_pkg;

  // Default width of the step counters.
  localparam int STEP_W_DEF      = 32;
  // Default per-phase watchdog limit, in clock cycles.
  localparam int WDOG_CYCLES_DEF = 1048576;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_P1_RUN = 3'd1,
    ST_P2_RUN = 3'd2,
    ST_SWAP   = 3'd3,
    ST_FIN    = 3'd4,
    ST_ERR    = 3'd5
  } seq_state_e;

endpackage

// File: rtl/phase_watchdog.sv
// Purpose: counts cycles spent inside one sequencer phase and flags when the limit is hit.
// Latency: expired is combinational from the registered count; it is high during the WDOG_CYCLES-th enabled cycle.
// Backpressure: none; clear overrides enable, the count holds when enable is low.
// Ports: clk/rst (async active-high) | clear restarts the count | enable counts this cycle | expired = limit reached.
module phase_watchdog
  import md_ctl_pkg::*;
#(
  parameter int WDOG_CYCLES = WDOG_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WDOG_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The count holds at LAST so it can never wrap back to zero while stalled.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The count is n-1 during the n-th enabled cycle of a phase.
  assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/timestep_sequencer.sv
// Purpose: sequences MD timesteps: force phase, motion-update phase, bank swap, repeated num_steps times.
// Latency: start to first p1_ready = 1 cycle; each step = max(p1 done cycle,2) + max(p2 done cycle,2) + 1 swap cycle.
// Backpressure: phases wait indefinitely on p1_done/p2_done; abort returns to IDLE on the next edge.
// Ports: clk, reset (async active-high) | start/abort/num_steps run control | p1_done/p2_done phase
//        completion | p1_ready/p2_ready phase strobes | double_buffer bank select | busy, run_done,
//        step_count, err status.
// Build option: define TIMESTEP_WATCHDOG_EN to add the per-phase watchdog and the ERR state.
module timestep_sequencer
  import md_ctl_pkg::*;
#(
  parameter int STEP_W      = STEP_W_DEF,
  parameter int WDOG_CYCLES = WDOG_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [STEP_W-1:0] num_steps,
  input  logic              p1_done,
  input  logic              p2_done,
  output logic              p1_ready,
  output logic              p2_ready,
  output logic              double_buffer,
  output logic              busy,
  output logic              run_done,
  output logic [STEP_W-1:0] step_count,
  output logic              err
);

  if (WDOG_CYCLES < 1) begin : g_bad_wdog_cfg
    $error("timestep_sequencer: WDOG_CYCLES must be at least 1");
  end

  seq_state_e        state_q, state_d;
  logic [STEP_W-1:0] steps_q, steps_d;
  logic [STEP_W-1:0] count_q, count_d;
  logic [STEP_W-1:0] count_inc;
  logic              db_q, db_d;
  logic              p1_rdy_q, p1_rdy_d;
  logic              p2_rdy_q, p2_rdy_d;
  logic              first_q, first_d;
  logic              phase_entry;
  logic              wdog_expired;

`ifdef TIMESTEP_WATCHDOG_EN
  logic err_q, err_d;
  logic in_phase;

  assign in_phase = (state_q == ST_P1_RUN) || (state_q == ST_P2_RUN);

  phase_watchdog #(
    .WDOG_CYCLES(WDOG_CYCLES)
  ) u_phase_watchdog (
    .clk     (clk),
    .rst     (reset),
    .clear   (phase_entry),
    .enable  (in_phase),
    .expired (wdog_expired)
  );

  assign err = err_q;
`else
  assign wdog_expired = 1'b0;
  assign err          = 1'b0;
`endif

  // Step counter wraps naturally modulo 2^STEP_W.
  assign count_inc = count_q + STEP_W'(1);

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      steps_q  <= '0;
      count_q  <= '0;
      db_q     <= 1'b0;
      p1_rdy_q <= 1'b0;
      p2_rdy_q <= 1'b0;
      first_q  <= 1'b0;
`ifdef TIMESTEP_WATCHDOG_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      steps_q  <= steps_d;
      count_q  <= count_d;
      db_q     <= db_d;
      p1_rdy_q <= p1_rdy_d;
      p2_rdy_q <= p2_rdy_d;
      first_q  <= first_d;
`ifdef TIMESTEP_WATCHDOG_EN
      err_q    <= err_d;
`endif
    end
  end

  // Next-state logic. Abort beats done, done beats the watchdog. first_q masks a done
  // left asserted from before the phase began.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (num_steps == '0) ? ST_FIN : ST_P1_RUN;
        end
      end
      ST_P1_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (!first_q && p1_done) begin
          state_d = ST_P2_RUN;
        end else if (wdog_expired) begin
          state_d = ST_ERR;
        end
      end
      ST_P2_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (!first_q && p2_done) begin
          state_d = ST_SWAP;
        end else if (wdog_expired) begin
          state_d = ST_ERR;
        end
      end
      ST_SWAP: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          state_d = (count_inc == steps_q) ? ST_FIN : ST_P1_RUN;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
`ifdef TIMESTEP_WATCHDOG_EN
      ST_ERR: begin
        if (abort || start) begin
          state_d = ST_IDLE;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output and datapath next values.
  always_comb begin
    steps_d = steps_q;
    count_d = count_q;
    db_d    = db_q;
`ifdef TIMESTEP_WATCHDOG_EN
    err_d   = err_q;
`endif

    if ((state_q == ST_IDLE) && start) begin
      steps_d = num_steps;
      count_d = '0;
`ifdef TIMESTEP_WATCHDOG_EN
      err_d   = 1'b0;
`endif
    end

    // An abort during SWAP leaves the bank and count untouched.
    if ((state_q == ST_SWAP) && !abort) begin
      db_d    = ~db_q;
      count_d = count_inc;
    end

`ifdef TIMESTEP_WATCHDOG_EN
    if (state_d == ST_ERR) begin
      err_d = 1'b1;
    end
`endif

    // Readies are registered copies of the upcoming state so they align with it exactly.
    p1_rdy_d    = (state_d == ST_P1_RUN);
    p2_rdy_d    = (state_d == ST_P2_RUN);
    phase_entry = (state_d != state_q) && ((state_d == ST_P1_RUN) || (state_d == ST_P2_RUN));
    first_d     = phase_entry;
  end

  assign p1_ready      = p1_rdy_q;
  assign p2_ready      = p2_rdy_q;
  assign double_buffer = db_q;
  assign busy          = (state_q != ST_IDLE);
  assign run_done      = (state_q == ST_FIN);
  assign step_count    = count_q;

endmodule

// File: tb/tb_timestep_sequencer.sv
`timescale 1ns/1ps
module tb_timestep_sequencer;

  localparam int STEP_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              abort;
  logic [STEP_W-1:0] num_steps;
  logic              p1_done;
  logic              p2_done;
  logic              p1_ready;
  logic              p2_ready;
  logic              double_buffer;
  logic              busy;
  logic              run_done;
  logic [STEP_W-1:0] step_count;
  logic              err;

  int checks = 0;
  int errors = 0;

  // Run stimulus and observations shared between the driver task and the tests.
  int   l1[8];
  int   l2[8];
  int   p1_lens[$];
  int   p2_lens[$];
  logic db_hist[$];
  int   dones;
  int   done_cyc;
  int   run_cyc;
  bit   timed_out;
  bit   p1_hold;
  int   abort_step;

  timestep_sequencer #(
    .STEP_W      (STEP_W),
    .WDOG_CYCLES (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .abort         (abort),
    .num_steps     (num_steps),
    .p1_done       (p1_done),
    .p2_done       (p2_done),
    .p1_ready      (p1_ready),
    .p2_ready      (p2_ready),
    .double_buffer (double_buffer),
    .busy          (busy),
    .run_done      (run_done),
    .step_count    (step_count),
    .err           (err)
  );

  always #5 clk = ~clk;

  // A phase whose done first appears in cycle l lasts max(l,2) cycles (first cycle ignores done).
  function automatic int ph_len(input int l);
    return (l < 2) ? 2 : l;
  endfunction

  // Expected cycle (1 = first cycle after the accepting edge) in which run_done is seen.
  function automatic int exp_done_cycle(input int n);
    int t;
    t = 1;
    for (int i = 0; i < n; i++) t += ph_len(l1[i]) + ph_len(l2[i]) + 1;
    return t;
  endfunction

  // Drives one run and records what happens; phase responders assert done in cycle l of each phase
  // and random noise on done outside its phase. Start is pulsed randomly while busy.
  task automatic run_steps(input int n);
    int   s;
    int   c1;
    int   c2;
    logic db_prev;
    p1_lens.delete();
    p2_lens.delete();
    db_hist.delete();
    dones = 0; done_cyc = 0; run_cyc = 0; timed_out = 0;
    s = 0; c1 = 0; c2 = 0;
    @(negedge clk);
    start = 1'b1;
    num_steps = STEP_W'(n);
    if (p1_hold) p1_done = 1'b1;
    @(negedge clk);
    start = 1'b0;
    num_steps = STEP_W'($urandom);
    db_prev = double_buffer;
    while (busy && !timed_out) begin
      run_cyc++;
      if (run_cyc > 600) timed_out = 1'b1;
      if (run_done) begin
        dones++;
        done_cyc = run_cyc;
      end
      if (double_buffer !== db_prev) begin
        db_hist.push_back(double_buffer);
        db_prev = double_buffer;
      end
      if (p1_ready) c1++;
      else if (c1 != 0) begin
        p1_lens.push_back(c1);
        c1 = 0;
      end
      if (p2_ready) c2++;
      else if (c2 != 0) begin
        p2_lens.push_back(c2);
        c2 = 0;
        s++;
      end
      abort = (abort_step == s) && (c2 == 1);
      start = (p1_ready || p2_ready) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (p1_hold) p1_done = 1'b1;
      else p1_done = p1_ready ? (c1 >= l1[s]) : 1'($urandom_range(0, 1));
      p2_done = p2_ready ? (c2 >= l2[s]) : 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    abort = 1'b0; start = 1'b0; p1_done = 1'b0; p2_done = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (p1_ready !== 1'b0 || p2_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b%b expected 00", p1_ready, p2_ready); end
    checks++; if (double_buffer !== 1'b0) begin errors++; $display("FAIL reset_db: got %b expected 0", double_buffer); end
    checks++; if (step_count !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", step_count); end
    checks++; if (run_done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_done_err: got %b%b expected 00", run_done, err); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy %b expected 0", busy); end
  endtask

  task automatic test_three_steps();
    for (int i = 0; i < 8; i++) begin l1[i] = 6; l2[i] = 3; end
    run_steps(3);
    checks++; if (timed_out) begin errors++; $display("FAIL three_timeout: run never finished"); end
    checks++; if (dones != 1) begin errors++; $display("FAIL three_dones: got %0d pulses expected 1", dones); end
    checks++; if (done_cyc != exp_done_cycle(3)) begin errors++; $display("FAIL three_latency: got %0d expected %0d", done_cyc, exp_done_cycle(3)); end
    checks++; if (db_hist.size() != 3) begin errors++; $display("FAIL three_swaps: got %0d toggles expected 3", db_hist.size()); end
    for (int i = 0; i < db_hist.size() && i < 3; i++) begin
      checks++;
      if (db_hist[i] !== ((i % 2) == 0)) begin errors++; $display("FAIL three_db_seq[%0d]: got %b expected %b", i, db_hist[i], (i % 2) == 0); end
    end
    checks++; if (step_count !== STEP_W'(3)) begin errors++; $display("FAIL three_count: got %0d expected 3", step_count); end
    for (int i = 0; i < p1_lens.size(); i++) begin
      checks++;
      if (p1_lens[i] != 6) begin errors++; $display("FAIL three_p1_len[%0d]: got %0d expected 6", i, p1_lens[i]); end
    end
  endtask

  task automatic test_zero_steps();
    logic db0;
    db0 = double_buffer;
    run_steps(0);
    checks++; if (dones != 1 || done_cyc != 1) begin errors++; $display("FAIL zero_done: got %0d pulses at cycle %0d expected 1 at 1", dones, done_cyc); end
    checks++; if (p1_lens.size() != 0 || p2_lens.size() != 0) begin errors++; $display("FAIL zero_ready: got %0d/%0d phases expected none", p1_lens.size(), p2_lens.size()); end
    checks++; if (step_count !== '0) begin errors++; $display("FAIL zero_count: got %0d expected 0", step_count); end
    checks++; if (double_buffer !== db0) begin errors++; $display("FAIL zero_db: got %b expected %b", double_buffer, db0); end
  endtask

  task automatic test_stale_done();
    p1_hold = 1'b1;
    p1_done = 1'b1;
    l2[0] = 2;
    @(negedge clk);
    run_steps(1);
    p1_hold = 1'b0;
    checks++; if (p1_lens.size() != 1) begin errors++; $display("FAIL stale_phases: got %0d expected 1", p1_lens.size()); end
    else begin
      checks++; if (p1_lens[0] != 2) begin errors++; $display("FAIL stale_p1_len: got %0d expected 2", p1_lens[0]); end
    end
    checks++; if (dones != 1) begin errors++; $display("FAIL stale_dones: got %0d expected 1", dones); end
  endtask

  task automatic test_abort();
    logic db0;
    int   late_done;
    db0 = double_buffer;
    for (int i = 0; i < 8; i++) begin l1[i] = $urandom_range(1, 4); l2[i] = $urandom_range(2, 4); end
    abort_step = 1;
    run_steps(4);
    abort_step = -1;
    checks++; if (timed_out) begin errors++; $display("FAIL abort_timeout: abort did not end run"); end
    checks++; if (dones != 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses expected 0", dones); end
    checks++; if (p1_ready !== 1'b0 || p2_ready !== 1'b0) begin errors++; $display("FAIL abort_ready: got %b%b expected 00", p1_ready, p2_ready); end
    checks++; if (step_count !== STEP_W'(1)) begin errors++; $display("FAIL abort_count: got %0d expected 1", step_count); end
    checks++; if (double_buffer !== ~db0) begin errors++; $display("FAIL abort_db: got %b expected %b", double_buffer, ~db0); end
    late_done = 0;
    repeat (4) begin
      @(negedge clk);
      if (run_done || busy) late_done++;
    end
    checks++; if (late_done != 0) begin errors++; $display("FAIL abort_idle: got %0d active cycles expected 0", late_done); end
  endtask

  task automatic test_random_runs();
    int   n;
    logic db0;
    for (int r = 0; r < 10; r++) begin
      n = $urandom_range(1, 5);
      for (int i = 0; i < 8; i++) begin l1[i] = $urandom_range(1, 6); l2[i] = $urandom_range(1, 6); end
      db0 = double_buffer;
      run_steps(n);
      checks++; if (timed_out || dones != 1) begin errors++; $display("FAIL rand%0d_done: got %0d pulses timeout=%0b expected 1", r, dones, timed_out); end
      checks++; if (done_cyc != exp_done_cycle(n)) begin errors++; $display("FAIL rand%0d_latency: got %0d expected %0d", r, done_cyc, exp_done_cycle(n)); end
      checks++; if (step_count !== STEP_W'(n)) begin errors++; $display("FAIL rand%0d_count: got %0d expected %0d", r, step_count, n); end
      checks++; if (double_buffer !== (db0 ^ n[0])) begin errors++; $display("FAIL rand%0d_db: got %b expected %b", r, double_buffer, db0 ^ n[0]); end
      checks++; if (p1_lens.size() != n || p2_lens.size() != n) begin errors++; $display("FAIL rand%0d_phases: got %0d/%0d expected %0d", r, p1_lens.size(), p2_lens.size(), n); end
      for (int i = 0; i < p1_lens.size() && i < n; i++) begin
        checks++;
        if (p1_lens[i] != ph_len(l1[i]) || p2_lens[i] != ph_len(l2[i]))
          begin errors++; $display("FAIL rand%0d_len[%0d]: got %0d/%0d expected %0d/%0d", r, i, p1_lens[i], p2_lens[i], ph_len(l1[i]), ph_len(l2[i])); end
      end
    end
  endtask

  task automatic test_watchdog();
    int cnt;
    @(negedge clk);
    start = 1'b1; num_steps = STEP_W'(2); p1_done = 1'b0;
    @(negedge clk);
    start = 1'b0;
`ifdef TIMESTEP_WATCHDOG_EN
    cnt = 0;
    while (p1_ready && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    checks++; if (cnt != 16) begin errors++; $display("FAIL wdog_cycles: got %0d P1 cycles expected 16", cnt); end
    checks++; if (err !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL wdog_err: got err %b busy %b expected 1 1", err, busy); end
    checks++; if (p1_ready !== 1'b0 || p2_ready !== 1'b0) begin errors++; $display("FAIL wdog_ready: got %b%b expected 00", p1_ready, p2_ready); end
    repeat (3) @(negedge clk);
    checks++; if (err !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL wdog_sticky: got err %b busy %b expected 1 1", err, busy); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wdog_exit: busy %b expected 0", busy); end
    start = 1'b1; num_steps = '0;
    @(negedge clk);
    start = 1'b0;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL wdog_clear: err %b expected 0", err); end
    @(negedge clk);
`else
    cnt = 0;
    repeat (40) begin
      if (p1_ready) cnt++;
      @(negedge clk);
    end
    checks++; if (cnt != 40 || err !== 1'b0) begin errors++; $display("FAIL stall_no_wdog: got %0d ready cycles err %b expected 40 0", cnt, err); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++; if (busy !== 1'b0 || p1_ready !== 1'b0) begin errors++; $display("FAIL stall_abort: got busy %b ready %b expected 0 0", busy, p1_ready); end
`endif
  endtask

  task automatic test_reset_mid_run();
    int seen_done;
    @(negedge clk);
    start = 1'b1; num_steps = STEP_W'(3); p1_done = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (p1_ready !== 1'b1) begin errors++; $display("FAIL midrst_setup: p1_ready %b expected 1", p1_ready); end
    #2 reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || p1_ready !== 1'b0 || p2_ready !== 1'b0) begin errors++; $display("FAIL midrst_async: busy %b ready %b%b expected 0 00", busy, p1_ready, p2_ready); end
    checks++; if (double_buffer !== 1'b0 || step_count !== '0 || err !== 1'b0 || run_done !== 1'b0)
      begin errors++; $display("FAIL midrst_state: db %b count %0d err %b done %b expected all 0", double_buffer, step_count, err, run_done); end
    seen_done = 0;
    repeat (2) begin
      @(negedge clk);
      if (run_done) seen_done++;
    end
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (run_done || busy) seen_done++;
    end
    checks++; if (seen_done != 0) begin errors++; $display("FAIL midrst_no_done: got %0d active cycles expected 0", seen_done); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; p1_done = 1'b0; p2_done = 1'b0;
    num_steps = '0; p1_hold = 1'b0; abort_step = -1;
    test_reset();
    test_three_steps();
    test_zero_steps();
    test_stale_done();
    test_abort();
    test_random_runs();
    test_watchdog();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/timestep_sequencer.md
TIMESTEP_SEQUENCER -- requirements
Module: timestep_sequencer

Interface
REQ-001 SHALL have parameter STEP_W, default 32: width of step counters.
REQ-002 SHALL have parameter WDOG_CYCLES, default 1048576: per-phase watchdog limit.
REQ-003 SHALL have port clk input 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port reset input 1: asynchronous, active-high reset.
REQ-005 SHALL have port start input 1: begin a run of num_steps timesteps (sampled in IDLE only).
REQ-006 SHALL have port abort input 1: terminate the run.
REQ-007 SHALL have port num_steps input STEP_W: timesteps to execute, latched on accepted start.
REQ-008 SHALL have port p1_done input 1: force-phase completion (phase_1 CTL_DONE).
REQ-009 SHALL have port p2_done input 1: motion-update completion.
REQ-010 SHALL have port p1_ready output 1: drives phase_1 CTL_READY.
REQ-011 SHALL have port p2_ready output 1: start of the motion-update phase.
REQ-012 SHALL have port double_buffer output 1: drives CTL_DOUBLE_BUFFER; selects the position bank.
REQ-013 SHALL have port busy output 1: high in any state except IDLE.
REQ-014 SHALL have port run_done output 1: one-cycle pulse at run completion.
REQ-015 SHALL have port step_count output STEP_W: completed timesteps in the current run.
REQ-016 SHALL have port err output 1: sticky watchdog error.

Function
REQ-017 SHALL implement states IDLE, P1_RUN, P2_RUN, SWAP, FIN, ERR; encoding registered.
REQ-018 SHALL, in IDLE with start=1, latch num_steps, clear step_count and err, then go to P1_RUN, or to FIN if num_steps=0.
REQ-019 SHALL hold p1_ready=1 for every cycle in P1_RUN and p2_ready=1 for every cycle in P2_RUN; both are 0 otherwise and are registered outputs.
REQ-020 SHALL ignore p1_done/p2_done in the first cycle of each phase (stale-done guard), then transition on the first cycle the respective done is 1.
REQ-021 SHALL go P1_RUN->P2_RUN->SWAP; SWAP lasts exactly 1 cycle.
REQ-022 SHALL, in SWAP, toggle double_buffer, increment step_count, then enter FIN if the new count equals the latched num_steps, else P1_RUN.
REQ-023 SHALL pulse run_done for exactly the 1 cycle spent in FIN, then return to IDLE.
REQ-024 SHALL, on abort=1 in any non-IDLE state, enter IDLE next cycle with readies low, no run_done, and double_buffer and step_count retained; abort has priority over done and watchdog.
REQ-025 SHALL ignore start while busy; step_count wraps modulo 2^STEP_W, with no other saturation.
REQ-026 SHALL ignore p1_done/p2_done outside their own phase.

Reset
REQ-027 SHALL, on reset, asynchronously force IDLE, p1_ready=0, p2_ready=0, double_buffer=0, busy=0, run_done=0, step_count=0, err=0, latched num_steps=0, and watchdog count=0.
REQ-028 SHALL, on reset mid-run, abandon the run without a run_done pulse.

Configuration
REQ-029 SHALL, with TIMESTEP_WATCHDOG_EN defined, count cycles in P1_RUN/P2_RUN (cleared on phase entry) and, on reaching WDOG_CYCLES, enter ERR with err=1 and readies low; ERR exits to IDLE only on start or abort; err clears on the next accepted start.
REQ-030 SHALL, without TIMESTEP_WATCHDOG_EN, omit the counter and ERR state, tying err to 0.

Structure
REQ-031 SHALL take the state enum, STEP_W default, and WDOG_CYCLES default from shared package md_ctl_pkg.
REQ-032 SHALL place the watchdog in sub-module phase_watchdog (clear, enable, expired), instantiated only under TIMESTEP_WATCHDOG_EN.

Verification
REQ-033 SHALL cover num_steps=3 with p1_done 5 cycles and p2_done 2 cycles after each ready: 3 SWAPs, double_buffer 0->1->0->1, step_count=3, one run_done pulse.
REQ-034 SHALL cover num_steps=0 with start: run_done 1 cycle later, no ready asserted, step_count=0.
REQ-035 SHALL cover p1_done held high continuously from before start: the first P1_RUN cycle is ignored, P2_RUN is entered on the second cycle.
REQ-036 SHALL cover abort in P2_RUN of step 2 with num_steps=4: IDLE next cycle, step_count=1, no run_done, double_buffer=1.
REQ-037 SHALL cover, with TIMESTEP_WATCHDOG_EN and WDOG_CYCLES=16, p1_done never asserted: err=1 after 16 P1_RUN cycles and readies low; start then clears err.
REQ-038 SHALL cover reset asserted mid-P1_RUN: all outputs at reset values immediately, without waiting for a clk edge.
